aes_core_arbiter: RTL and testbench

// - Shares one AES-128 encrypt core (load/start/key/iBlock/oBlock/idle interface) among NUM_REQ requesters (OFB/CTR/CBC mode engines).
// - Grants requests round-robin and caches the expanded key: it issues core_load only when the granted key differs from the loaded key.
// - Returns each ciphertext tagged with the requester id. It sits between the mode engines and a single core instance.

---
 rtl/aes_arb_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/aes_core_arbiter.sv | 157 +++++++++++++++
 tb/tb_aes_core_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_arb_pkg.sv
// Shared types for the AES core arbiter: FSM state encoding and block width.
package aes_arb_pkg;

    localparam int BLOCK_W = 128;

    typedef enum logic [2:0] {
        ARB_IDLE,
        LOAD,
        LOAD_WAIT,
        START,
        RUN_WAIT,
        RESP
    } ArbState_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] g,
    output logic          any
);

    logic [IW-1:0] idx;

    // Scan from the farthest offset down so the nearest hit to ptr wins.
    always_comb begin
        gnt = '0;
        g   = '0;
        any = 1'b0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                g        = idx;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES-128 core among NUM_REQ requesters, round-robin, with a
// single-entry expanded-key cache so repeated keys skip the key load.
module aes_core_arbiter
    import aes_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*BLOCK_W-1:0] req_key,
    input  logic [NUM_REQ*BLOCK_W-1:0] req_block,
    input  logic                       flush,
    output logic                       rsp_valid,
    output logic [ID_W-1:0]            rsp_id,
    output logic [BLOCK_W-1:0]         rsp_block,
    output logic                       busy,
    output logic                       core_load,
    output logic                       core_start,
    output logic [BLOCK_W-1:0]         core_key,
    output logic [BLOCK_W-1:0]         core_iblock,
    input  logic [BLOCK_W-1:0]         core_oblock,
    input  logic                       core_idle
);

    ArbState_t          state_reg, state_next;
    logic [ID_W-1:0]    ptr_reg;
    logic [ID_W-1:0]    id_reg;
    logic [ID_W-1:0]    rsp_id_reg;
    logic               key_vld_reg;
    logic               guard_reg;
    logic [BLOCK_W-1:0] key_reg;
    logic [BLOCK_W-1:0] blk_reg;
    logic [BLOCK_W-1:0] rsp_block_reg;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    g;
    logic               any;
    logic               grant;
    logic               key_hit;
    logic               set_vld;
    logic               capture;

    logic [BLOCK_W-1:0] key_arr [NUM_REQ];
    logic [BLOCK_W-1:0] blk_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign key_arr[gi] = req_key[gi*BLOCK_W +: BLOCK_W];
            assign blk_arr[gi] = req_block[gi*BLOCK_W +: BLOCK_W];
        end
    endgenerate

    rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_rr (
        .req (req_valid),
        .ptr (ptr_reg),
        .gnt (gnt),
        .g   (g),
        .any (any)
    );

    // A flush in the grant cycle must force a reload, so it vetoes the hit.
    assign key_hit = key_vld_reg && !flush && (key_arr[g] == key_reg);

    assign busy        = (state_reg != ARB_IDLE);
    assign core_key    = key_reg;
    assign core_iblock = blk_reg;
    assign rsp_id      = rsp_id_reg;
    assign rsp_block   = rsp_block_reg;

    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        core_load  = 1'b0;
        core_start = 1'b0;
        rsp_valid  = 1'b0;
        grant      = 1'b0;
        set_vld    = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            ARB_IDLE: begin
                // Grant is suppressed while rst is held so every output reads 0.
                if (any && !rst) begin
                    req_ready  = gnt;
                    grant      = 1'b1;
                    state_next = key_hit ? START : LOAD;
                end
            end
            LOAD: begin
                if (core_idle) begin
                    core_load  = 1'b1;
                    state_next = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                if (!guard_reg && core_idle) begin
                    set_vld    = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (core_idle) begin
                    core_start = 1'b1;
                    state_next = RUN_WAIT;
                end
            end
            RUN_WAIT: begin
                if (!guard_reg && core_idle) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ARB_IDLE;
            ptr_reg       <= '0;
            id_reg        <= '0;
            rsp_id_reg    <= '0;
            key_vld_reg   <= 1'b0;
            guard_reg     <= 1'b0;
            key_reg       <= '0;
            blk_reg       <= '0;
            rsp_block_reg <= '0;
        end else begin
            state_reg <= state_next;
            // core_idle lags a load/start by one cycle; ignore it for that cycle.
            guard_reg <= core_load | core_start;
            if (grant) begin
                key_reg <= key_arr[g];
                blk_reg <= blk_arr[g];
                id_reg  <= g;
                ptr_reg <= (g == ID_W'(NUM_REQ - 1)) ? '0 : g + ID_W'(1);
            end
            if (flush || (grant && !key_hit)) begin
                key_vld_reg <= 1'b0;
            end else if (set_vld) begin
                key_vld_reg <= 1'b1;
            end
            if (capture) begin
                rsp_block_reg <= core_oblock;
                rsp_id_reg    <= id_reg;
            end
        end
    end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Randomized and directed bench for aes_core_arbiter with a behavioural AES-128
// core and a transaction-level scoreboard of grants, key loads and responses.
module tb_aes_core_arbiter;

    localparam int N  = 4;
    localparam int BW = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*BW-1:0]   req_key;
    logic [N*BW-1:0]   req_block;
    logic              flush;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [BW-1:0]     rsp_block;
    logic              busy;
    logic              core_load;
    logic              core_start;
    logic [BW-1:0]     core_key;
    logic [BW-1:0]     core_iblock;
    logic [BW-1:0]     core_oblock;
    logic              core_idle;

    aes_core_arbiter #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_key     (req_key),
        .req_block   (req_block),
        .flush       (flush),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_block   (rsp_block),
        .busy        (busy),
        .core_load   (core_load),
        .core_start  (core_start),
        .core_key    (core_key),
        .core_iblock (core_iblock),
        .core_oblock (core_oblock),
        .core_idle   (core_idle)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- behavioural AES-128 ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] t = {v, v};
        t = t << n;
        return t[15:8];
    endfunction

    task automatic init_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[c*4+r] = s[c*4+r] ^ w[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[c*4+r] = s[((c+r)%4)*4+r];
            for (int c = 0; c < 4; c++) begin
                a0 = t[c*4]; a1 = t[c*4+1]; a2 = t[c*4+2]; a3 = t[c*4+3];
                if (rnd < 10) begin
                    s[c*4]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[c*4+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[c*4+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[c*4+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[c*4] = a0; s[c*4+1] = a1; s[c*4+2] = a2; s[c*4+3] = a3;
                end
                for (int r = 0; r < 4; r++) s[c*4+r] = s[c*4+r] ^ w[4*rnd+c][31-8*r -: 8];
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- core model: random latency, reset by rst ----------------
    logic [BW-1:0] core_kreg;
    int            core_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_idle   <= 1'b1;
            core_oblock <= '0;
            core_kreg   <= '0;
            core_cnt    <= 0;
        end else if (core_load) begin
            core_kreg <= core_key;
            core_idle <= 1'b0;
            core_cnt  <= int'($urandom_range(4, 1));
        end else if (core_start) begin
            core_oblock <= aes128(core_kreg, core_iblock);
            core_idle   <= 1'b0;
            core_cnt    <= int'($urandom_range(4, 1));
        end else if (!core_idle) begin
            if (core_cnt <= 1) core_idle <= 1'b1;
            core_cnt <= core_cnt - 1;
        end
    end

    // ---------------- reference model / scoreboard ----------------
    int            mptr = 0;
    logic          cache_vld = 1'b0;
    logic [BW-1:0] cache_key = '0;
    logic          inflight = 1'b0;
    logic          cur_miss;
    logic [BW-1:0] cur_key, cur_blk;
    int            cur_id;
    int            loads, wait_cnt, cyc = 0;
    int            ready_cyc, start_cyc;
    int            rsp_cnt = 0;
    int            last_loads;
    int            gcount [N];
    int            grant_log [$];

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    initial for (int i = 0; i < N; i++) gcount[i] = 0;

    always @(negedge clk) begin
        int           g;
        logic         was_inflight;
        logic [N-1:0] expg;
        if (rst) begin
            mptr = 0; cache_vld = 1'b0; cache_key = '0; inflight = 1'b0;
        end else begin
            cyc++;
            was_inflight = inflight;
            check("core_excl", 128'(core_load & core_start), 128'(0));
            check("core_pulse_busy", 128'((core_load | core_start) & ~core_idle), 128'(0));
            check("busy", 128'(busy), 128'(was_inflight));
            g = inflight ? -1 : rr_pick(req_valid, mptr);
            expg = '0;
            if (g >= 0) expg[g] = 1'b1;
            check("grant", 128'(req_ready), 128'(expg));
            if (g >= 0) begin
                cur_key  = req_key[g*BW +: BW];
                cur_blk  = req_block[g*BW +: BW];
                cur_id   = g;
                cur_miss = !cache_vld || flush || (cur_key != cache_key);
                if (cur_miss) cache_vld = 1'b0;
                inflight = 1'b1;
                loads = 0; wait_cnt = 0; ready_cyc = cyc;
                mptr = (g + 1) % N;
                gcount[g]++;
                grant_log.push_back(g);
            end else if (flush && !was_inflight) begin
                cache_vld = 1'b0;
            end
            if (core_load) loads++;
            if (core_start) start_cyc = cyc;
            if (rsp_valid) begin
                if (!inflight) begin
                    check("rsp_unexpected", 128'(rsp_valid), 128'(0));
                end else begin
                    check("rsp_id", 128'(rsp_id), 128'(cur_id));
                    check("rsp_block", rsp_block, aes128(cur_key, cur_blk));
                    check("core_loads", 128'(loads), 128'(cur_miss ? 1 : 0));
                    $display("txn id=%0d key=%h miss=%0d loads=%0d rsp=%h", cur_id, cur_key, cur_miss, loads, rsp_block);
                    if (cur_miss) begin
                        cache_key = cur_key;
                        cache_vld = 1'b1;
                    end
                    last_loads = loads;
                    inflight = 1'b0;
                    rsp_cnt++;
                end
            end
            if (inflight) begin
                wait_cnt++;
                if (wait_cnt > 300) begin
                    check("txn_timeout", 128'(1), 128'(0));
                    inflight = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tx(input int i, input logic [BW-1:0] k, input logic [BW-1:0] b, input logic fl);
        int n;
        int r0;
        r0 = rsp_cnt;
        @(posedge clk); #1;
        req_key[i*BW +: BW]   = k;
        req_block[i*BW +: BW] = b;
        req_valid[i]          = 1'b1;
        flush                 = fl;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[i] && n < 100);
        check("tx_grant_seen", 128'(req_ready[i]), 128'(1));
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        flush        = 1'b0;
        n = 0;
        while (rsp_cnt == r0 && n < 300) begin @(posedge clk); n++; end
        check("tx_rsp_seen", 128'(rsp_cnt - r0), 128'(1));
    endtask

    task automatic new_req(input int i, input logic [BW-1:0] k);
        req_key[i*BW +: BW]   = k;
        req_block[i*BW +: BW] = {$urandom, $urandom, $urandom, $urandom};
        req_valid[i]          = 1'b1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    logic [BW-1:0] k1, b1, exp1, ka, kb, kc, bc;
    logic [BW-1:0] kpool [3];
    int            seen [N];

    initial begin
        int n;
        int r0;
        rst = 1'b1; req_valid = '0; flush = 1'b0; req_key = '0; req_block = '0;
        init_sbox();
        k1   = 128'h000102030405060708090a0b0c0d0e0f;
        b1   = 128'h00112233445566778899aabbccddeeff;
        exp1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        ka   = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
        kb   = 128'h5A5A_FFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999;
        kc   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        bc   = 128'h3243f6a8885a308d313198a2e0370734;
        kpool[0] = k1; kpool[1] = ka; kpool[2] = kb;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst_core_pulses", 128'({core_load, core_start}), 128'(0));
        check("rst_core_key", core_key, 128'(0));
        check("rst_rsp_block", rsp_block, 128'(0));
        @(posedge clk); #1 rst = 1'b0;

        // known-answer: first request loads, second hits
        tx(0, k1, b1, 1'b0);
        check("kat_block", rsp_block, exp1);
        check("kat_id", 128'(rsp_id), 128'(0));
        check("kat_loads", 128'(last_loads), 128'(1));
        tx(0, k1, b1, 1'b0);
        check("hit_loads", 128'(last_loads), 128'(0));
        check("hit_latency", 128'(start_cyc - ready_cyc), 128'(1));
        check("hit_block", rsp_block, exp1);

        // alternating keys each miss
        tx(1, ka, b1, 1'b0); check("alt_a_loads", 128'(last_loads), 128'(1));
        tx(2, kb, b1, 1'b0); check("alt_b_loads", 128'(last_loads), 128'(1));
        tx(1, ka, b1, 1'b0); check("alt_a2_loads", 128'(last_loads), 128'(1));

        // flush handling
        tx(1, ka, bc, 1'b0); check("pre_flush_hit", 128'(last_loads), 128'(0));
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        tx(1, ka, bc, 1'b0); check("post_flush_loads", 128'(last_loads), 128'(1));
        tx(1, ka, bc, 1'b1); check("flush_at_grant_loads", 128'(last_loads), 128'(1));

        // round robin from ptr 0 with all requesters holding the same key
        pulse_reset();
        grant_log.delete();
        r0 = rsp_cnt;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            req_key[i*BW +: BW]   = k1;
            req_block[i*BW +: BW] = {$urandom, $urandom, $urandom, $urandom};
        end
        req_valid = '1;
        n = 0;
        while (grant_log.size() < 5 && n < 400) begin @(posedge clk); n++; end
        #1 req_valid = '0;
        n = 0;
        while (inflight && n < 300) begin @(posedge clk); n++; end
        check("rr_grant_count", 128'(grant_log.size()), 128'(5));
        for (int k = 0; k < grant_log.size() && k < 5; k++)
            check("rr_order", 128'(grant_log[k]), 128'(k % N));
        check("rr_rsp_count", 128'(rsp_cnt - r0), 128'(5));

        // reset while the core is running: no response, then a fresh request reloads
        @(posedge clk); #1;
        req_key[3*BW +: BW] = kc; req_block[3*BW +: BW] = bc; req_valid[3] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[3] && n < 100);
        @(posedge clk); #1 req_valid[3] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!core_start && n < 100);
        check("rw_start_seen", 128'(core_start), 128'(1));
        r0 = rsp_cnt;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("rw_rst_outputs", 128'({busy, rsp_valid, core_load, core_start, req_ready}), 128'(0));
        check("rw_rst_core_key", core_key, 128'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        check("rw_no_rsp", 128'(rsp_cnt - r0), 128'(0));
        tx(3, kc, bc, 1'b0);
        check("rw_fresh_loads", 128'(last_loads), 128'(1));
        check("rw_fresh_block", rsp_block, 128'h3925841d02dc09fbdc118597196a0b32);

        // randomized traffic
        for (int i = 0; i < N; i++) seen[i] = gcount[i];
        for (int c = 0; c < 2500; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (gcount[i] != seen[i]) begin
                    seen[i] = gcount[i];
                    if ($urandom % 4 != 0) new_req(i, kpool[$urandom % 3]);
                    else req_valid[i] = 1'b0;
                end else if (!req_valid[i] && ($urandom % 3 == 0)) begin
                    new_req(i, kpool[$urandom % 3]);
                end
            end
            flush = !inflight && ($urandom % 10 == 0);
        end
        @(posedge clk); #1 req_valid = '0; flush = 1'b0;
        n = 0;
        while (inflight && n < 400) begin @(posedge clk); n++; end
        check("drain_idle", 128'(inflight), 128'(0));
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
